gsu_mem_if: RTL and testbench

GSU-side memory requester for the shared ROM/SaveRAM SRAM. Accepts GSU ROM-fetch and RAM read/write requests, translates GSU bank/offset addresses into the same linear SRAM layout used for SNES accesses (ROM from 000000, SaveRAM at E00000), and arbitrates between them. Each selected request is sequenced through a req/ack handshake to the memory controller, and the block backs off while the SNES owns the bus.

---
 rtl/gsu_mem_pkg.sv | 17 +
 rtl/gsu_mem_bus_if.sv | 19 +
 rtl/gsu_mem_xlate.sv | 30 +++
 rtl/gsu_mem_if.sv | 136 +++++++++++++
 tb/tb_gsu_mem_if.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gsu_mem_pkg.sv
// Shared types and constants for the GSU-side SRAM requester.
package gsu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    CLI_ROM = 1'b0,
    CLI_RAM = 1'b1
  } client_e;

  localparam logic [23:0] SAVERAM_BASE = 24'hE00000;

endpackage

// File: rtl/gsu_mem_bus_if.sv
// Memory-controller side of the shared SRAM port: req/ack handshake plus data.
interface gsu_mem_bus_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/gsu_mem_xlate.sv
// Combinational GSU bank/offset to linear SRAM address translation
// (ROM from 000000, SaveRAM at SAVERAM_BASE).
module gsu_mem_xlate
  import gsu_mem_pkg::*;
(
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic        is_ram,
  input  logic [23:0] rom_mask,
  input  logic [23:0] saveram_mask,
  output logic [23:0] lin_addr
);

  logic [23:0] rom_lin;
  logic [23:0] ram_off;
  logic        unused_bank7;

  // Bank bit 7 is a mirror and never reaches the SRAM address.
  assign unused_bank7 = bank[7];

  always_comb begin
    // Banks with bit 6 set map a full 64 KiB; others map only the upper 32 KiB half.
    if (bank[6]) rom_lin = {2'b00, bank[5:0], addr};
    else         rom_lin = {2'b00, bank[6:0], addr[14:0]};

    ram_off  = {7'd0, bank[0], addr} & saveram_mask;
    lin_addr = is_ram ? (SAVERAM_BASE + ram_off) : (rom_lin & rom_mask);
  end

endmodule

// File: rtl/gsu_mem_if.sv
// GSU-side SRAM requester: round-robin between ROM fetch and RAM client,
// one req/ack transaction at a time, backing off while the SNES owns the bus.
module gsu_mem_if
  import gsu_mem_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [23:0]   ROM_MASK,
  input  logic [23:0]   SAVERAM_MASK,
  input  logic          SNES_ACTIVE,
  input  logic          GSU_RON,
  input  logic          GSU_RAN,
  input  logic          rom_req,
  input  logic [7:0]    rom_bank,
  input  logic [15:0]   rom_addr,
  output logic          rom_ack,
  output logic [7:0]    rom_data,
  input  logic          ram_req,
  input  logic          ram_we,
  input  logic [7:0]    ram_bank,
  input  logic [15:0]   ram_addr,
  input  logic [7:0]    ram_wdata,
  output logic          ram_ack,
  output logic [7:0]    ram_rdata,
  gsu_mem_bus_if.master mem
);

  state_e      state_q, state_d;
  client_e     cur_q, cur_d;
  client_e     last_q, last_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [7:0]  ram_rdata_q, ram_rdata_d;

  logic        rom_elig, ram_elig;
  client_e     win;
  logic [23:0] win_addr;

  assign rom_ack = (state_q == ST_DONE) && (cur_q == CLI_ROM);
  assign ram_ack = (state_q == ST_DONE) && (cur_q == CLI_RAM);

  assign rom_elig = rom_req && GSU_RON && !rom_ack;
  assign ram_elig = ram_req && GSU_RAN && !ram_ack;

  // On a tie the client not served last goes next.
  always_comb begin
    if (rom_elig && ram_elig) win = (last_q == CLI_ROM) ? CLI_RAM : CLI_ROM;
    else if (ram_elig)        win = CLI_RAM;
    else                      win = CLI_ROM;
  end

  gsu_mem_xlate u_xlate (
    .bank         (win == CLI_RAM ? ram_bank : rom_bank),
    .addr         (win == CLI_RAM ? ram_addr : rom_addr),
    .is_ram       (win == CLI_RAM),
    .rom_mask     (ROM_MASK),
    .saveram_mask (SAVERAM_MASK),
    .lin_addr     (win_addr)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rom_data_d  = rom_data_q;
    ram_rdata_d = ram_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!SNES_ACTIVE && (rom_elig || ram_elig)) begin
          cur_d   = win;
          req_d   = 1'b1;
          addr_d  = win_addr;
          we_d    = (win == CLI_RAM) && ram_we;
          wdata_d = (win == CLI_RAM) ? ram_wdata : wdata_q;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Once issued, the access runs to completion regardless of SNES or grants.
        if (mem.MEM_ACK) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (cur_q == CLI_ROM)  rom_data_d  = mem.MEM_RDATA;
          else if (!we_q)        ram_rdata_d = mem.MEM_RDATA;
        end
      end
      ST_DONE: begin
        last_d  = cur_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cur_q       <= CLI_ROM;
      last_q      <= CLI_ROM;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 24'd0;
      wdata_q     <= 8'd0;
      rom_data_q  <= 8'd0;
      ram_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rom_data_q  <= rom_data_d;
      ram_rdata_q <= ram_rdata_d;
    end
  end

  assign mem.MEM_REQ   = req_q;
  assign mem.MEM_WE    = we_q;
  assign mem.MEM_ADDR  = addr_q;
  assign mem.MEM_WDATA = wdata_q;
  assign rom_data      = rom_data_q;
  assign ram_rdata     = ram_rdata_q;

endmodule

// File: tb/tb_gsu_mem_if.sv
// Directed bench for gsu_mem_if: translation, handshake timing, round-robin,
// SNES backoff and asynchronous reset during an access.
module tb_gsu_mem_if;
  import gsu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] rom_mask, saveram_mask;
  logic        snes_active, gsu_ron, gsu_ran;
  logic        rom_req, rom_ack;
  logic [7:0]  rom_bank, rom_data;
  logic [15:0] rom_addr;
  logic        ram_req, ram_we, ram_ack;
  logic [7:0]  ram_bank, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  int checks = 0;
  int errors = 0;

  gsu_mem_bus_if bus ();

  gsu_mem_if dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .ROM_MASK     (rom_mask),
    .SAVERAM_MASK (saveram_mask),
    .SNES_ACTIVE  (snes_active),
    .GSU_RON      (gsu_ron),
    .GSU_RAN      (gsu_ran),
    .rom_req      (rom_req),
    .rom_bank     (rom_bank),
    .rom_addr     (rom_addr),
    .rom_ack      (rom_ack),
    .rom_data     (rom_data),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_bank     (ram_bank),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_ack      (ram_ack),
    .ram_rdata    (ram_rdata),
    .mem          (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.MEM_REQ !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check(tag, {23'd0, bus.MEM_REQ}, 24'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_ram;

    rst_n = 1'b0;
    rom_mask = 24'h1FFFFF; saveram_mask = 24'h007FFF;
    snes_active = 1'b0; gsu_ron = 1'b0; gsu_ran = 1'b0;
    rom_req = 1'b0; rom_bank = 8'h00; rom_addr = 16'h0000;
    ram_req = 1'b0; ram_we = 1'b0; ram_bank = 8'h00; ram_addr = 16'h0000; ram_wdata = 8'h00;
    bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 8'h00;
    #2;
    check("rst_mem_req",   {23'd0, bus.MEM_REQ}, 24'd0);
    check("rst_mem_we",    {23'd0, bus.MEM_WE}, 24'd0);
    check("rst_mem_addr",  bus.MEM_ADDR, 24'd0);
    check("rst_mem_wdata", {16'd0, bus.MEM_WDATA}, 24'd0);
    check("rst_acks",      {22'd0, rom_ack, ram_ack}, 24'd0);
    check("rst_data",      {8'd0, rom_data, ram_rdata}, 24'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ROM low bank: 01:8123 -> 008123, ack one cycle after MEM_REQ.
    rom_bank = 8'h01; rom_addr = 16'h8123; gsu_ron = 1'b1; rom_req = 1'b1;
    #1;
    check("lo_no_req_yet", {23'd0, bus.MEM_REQ}, 24'd0);
    tick();
    check("lo_req",  {23'd0, bus.MEM_REQ}, 24'd1);
    check("lo_addr", bus.MEM_ADDR, 24'h008123);
    check("lo_we",   {23'd0, bus.MEM_WE}, 24'd0);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'hA5;
    tick();
    bus.MEM_ACK = 1'b0; rom_req = 1'b0;
    check("lo_req_drop", {23'd0, bus.MEM_REQ}, 24'd0);
    check("lo_ack",      {22'd0, rom_ack, ram_ack}, 24'b10);
    check("lo_data",     {16'd0, rom_data}, 24'h0000A5);
    tick();
    check("lo_ack_pulse", {23'd0, rom_ack}, 24'd0);
    check("lo_data_hold", {16'd0, rom_data}, 24'h0000A5);

    // ROM high bank, then with a 64 KiB mask.
    rom_bank = 8'h41; rom_addr = 16'h2345; rom_req = 1'b1;
    tick();
    check("hi_addr", bus.MEM_ADDR, 24'h012345);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'h5A;
    tick();
    bus.MEM_ACK = 1'b0; rom_req = 1'b0;
    check("hi_data", {16'd0, rom_data}, 24'h00005A);
    tick();
    rom_mask = 24'h00FFFF; rom_req = 1'b1;
    tick();
    check("hi_mask_addr", bus.MEM_ADDR, 24'h002345);
    bus.MEM_ACK = 1'b1;
    tick();
    bus.MEM_ACK = 1'b0; rom_req = 1'b0;
    check("hi_mask_ack", {23'd0, rom_ack}, 24'd1);
    tick();

    // MEM_ACK while idle is ignored.
    bus.MEM_ACK = 1'b1;
    tick();
    bus.MEM_ACK = 1'b0;
    check("idle_ack_ignored", {21'd0, bus.MEM_REQ, rom_ack, ram_ack}, 24'd0);

    // Round-robin: last served was ROM, so the tie goes RAM, ROM, RAM, ROM.
    gsu_ran = 1'b1; ram_bank = 8'h71; ram_addr = 16'h0010; ram_we = 1'b0;
    rom_req = 1'b1; ram_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_ram = (i % 2 == 0);
      wait_req($sformatf("rr%0d_req", i));
      check($sformatf("rr%0d_addr", i), bus.MEM_ADDR, exp_ram ? 24'hE00010 : 24'h002345);
      bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'h10 + 8'(i);
      tick();
      bus.MEM_ACK = 1'b0;
      check($sformatf("rr%0d_ack", i), {22'd0, rom_ack, ram_ack}, exp_ram ? 24'b01 : 24'b10);
      check($sformatf("rr%0d_data", i), {16'd0, exp_ram ? ram_rdata : rom_data}, 24'h10 + 24'(i));
      tick();
    end

    // RAM grant removed: only ROM is served even with both requesting.
    gsu_ran = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_req($sformatf("ron%0d_req", i));
      check($sformatf("ron%0d_addr", i), bus.MEM_ADDR, 24'h002345);
      bus.MEM_ACK = 1'b1;
      tick();
      bus.MEM_ACK = 1'b0;
      check($sformatf("ron%0d_ack", i), {22'd0, rom_ack, ram_ack}, 24'b10);
      tick();
    end
    rom_req = 1'b0; ram_req = 1'b0;
    tick();
    gsu_ran = 1'b1;

    // RAM write: SaveRAM mask folds bank bit 0 away, data is not returned.
    ram_we = 1'b1; ram_wdata = 8'h3C; ram_req = 1'b1;
    tick();
    check("wr_addr",  bus.MEM_ADDR, 24'hE00010);
    check("wr_we",    {23'd0, bus.MEM_WE}, 24'd1);
    check("wr_wdata", {16'd0, bus.MEM_WDATA}, 24'h00003C);
    tick();
    check("wr_busy_hold", {22'd0, bus.MEM_REQ, ram_ack}, 24'b10);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'hFF;
    tick();
    bus.MEM_ACK = 1'b0; ram_req = 1'b0;
    check("wr_ack",   {23'd0, ram_ack}, 24'd1);
    check("wr_rdata", {16'd0, ram_rdata}, 24'h000012);
    tick();

    // RAM read with the full 17-bit mask: bank bit 0 reaches the address.
    saveram_mask = 24'h01FFFF; ram_we = 1'b0; ram_req = 1'b1;
    tick();
    check("rd_addr", bus.MEM_ADDR, 24'hE10010);
    check("rd_we",   {23'd0, bus.MEM_WE}, 24'd0);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'h77;
    tick();
    bus.MEM_ACK = 1'b0; ram_req = 1'b0;
    check("rd_rdata", {16'd0, ram_rdata}, 24'h000077);
    tick();

    // SNES owns the bus: no issue until it lets go.
    snes_active = 1'b1; rom_req = 1'b1;
    tick(); tick(); tick();
    check("snes_backoff", {23'd0, bus.MEM_REQ}, 24'd0);
    snes_active = 1'b0;
    tick();
    check("snes_release_req", {23'd0, bus.MEM_REQ}, 24'd1);
    snes_active = 1'b1; gsu_ron = 1'b0;
    tick();
    check("snes_mid_busy_hold", {23'd0, bus.MEM_REQ}, 24'd1);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'hC3;
    tick();
    bus.MEM_ACK = 1'b0; rom_req = 1'b0;
    check("snes_mid_busy_ack", {23'd0, rom_ack}, 24'd1);
    check("snes_mid_busy_data", {16'd0, rom_data}, 24'h0000C3);
    snes_active = 1'b0; gsu_ron = 1'b1;
    tick();

    // Asynchronous reset while BUSY abandons the access.
    rom_req = 1'b1;
    tick();
    check("rstb_req", {23'd0, bus.MEM_REQ}, 24'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstb_outputs", {20'd0, bus.MEM_REQ, bus.MEM_WE, rom_ack, ram_ack}, 24'd0);
    check("rstb_addr",    bus.MEM_ADDR, 24'd0);
    check("rstb_data",    {8'd0, rom_data, ram_rdata}, 24'd0);
    bus.MEM_ACK = 1'b1;
    tick();
    bus.MEM_ACK = 1'b0;
    check("rstb_no_ack", {22'd0, rom_ack, ram_ack}, 24'd0);
    rst_n = 1'b1;
    tick();
    check("rstb_reissue_req",  {23'd0, bus.MEM_REQ}, 24'd1);
    check("rstb_reissue_addr", bus.MEM_ADDR, 24'h002345);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 8'h99;
    tick();
    bus.MEM_ACK = 1'b0; rom_req = 1'b0;
    check("rstb_reissue_ack", {22'd0, rom_ack, ram_ack}, 24'b10);
    check("rstb_reissue_data", {16'd0, rom_data}, 24'h000099);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
